// File: rtl/windowed_majority_filter.sv
`default_nettype none
// ============================================================================
// Module   : windowed_majority_filter
// Purpose  : Per-channel sliding-window k-of-WIN vote over the last WIN
//            accepted samples of CH independent 1-bit channels.
// Revision : 1.0 - initial release
// ============================================================================
module windowed_majority_filter #(
  parameter int CH     = 4,
  parameter int WIN    = 5,
  parameter int THRESH = (WIN + 1) / 2,
  parameter int CW     = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [CH-1:0] in_bits,
  output logic [CH-1:0] maj,
  output logic          out_valid,
  output logic          full,
  output logic [CW-1:0] ones0
);

  localparam logic [CW-1:0] c_WIN_CW    = CW'(WIN);
  localparam logic [CW-1:0] c_THRESH_CW = CW'(THRESH);

  // History per channel, bit 0 is the newest accepted sample.
  logic [CH-1:0][WIN-1:0] r_hist;
  logic [CH-1:0][CW-1:0]  r_ones;
  logic [CW-1:0]          r_fill;
  logic [CH-1:0]          r_maj;
  logic                   r_out_valid;
  logic                   r_full;

  logic                   w_win_full;
  logic [CW-1:0]          w_fill_next;
  logic                   w_full_next;
  logic [CH-1:0][CW-1:0]  w_ones_next;
  logic [CH-1:0]          w_vote;

  // Next fill level and per-channel running counts for an accepted sample.
  // The count is kept modulo 2^CW: the true result always lies in 0..WIN,
  // so any transient wrap of the add/subtract cancels out.
  always_comb begin
    w_win_full  = (r_fill == c_WIN_CW);
    w_fill_next = w_win_full ? r_fill : (r_fill + CW'(1));
    w_full_next = (w_fill_next == c_WIN_CW);
    w_ones_next = '0;
    w_vote      = '0;
    for (int c = 0; c < CH; c++) begin
      w_ones_next[c] = r_ones[c] + CW'(in_bits[c])
                       - CW'(w_win_full & r_hist[c][WIN-1]);
      w_vote[c]      = (w_ones_next[c] >= c_THRESH_CW);
    end
  end

  // Window state and registered outputs; clr beats a coincident sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist      <= '0;
      r_ones      <= '0;
      r_fill      <= '0;
      r_maj       <= '0;
      r_out_valid <= 1'b0;
      r_full      <= 1'b0;
    end else if (clr) begin
      r_hist      <= '0;
      r_ones      <= '0;
      r_fill      <= '0;
      r_maj       <= '0;
      r_out_valid <= 1'b0;
      r_full      <= 1'b0;
    end else if (in_valid) begin
      for (int c = 0; c < CH; c++) begin
        r_hist[c] <= {r_hist[c][WIN-2:0], in_bits[c]};
      end
      r_ones      <= w_ones_next;
      r_fill      <= w_fill_next;
      r_full      <= w_full_next;
      r_out_valid <= w_full_next;
      r_maj       <= w_full_next ? w_vote : '0;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign maj       = r_maj;
  assign out_valid = r_out_valid;
  assign full      = r_full;
  assign ones0     = r_ones[0];

endmodule
`default_nettype wire
